// File: rtl/mpa_mips_32.sv
// mpa_mips_32: single-cycle 32-bit MIPS subset core with internal IM/DM/register file
// and a debug port that halts the core and gives direct access to all three arrays.
module mpa_mips_32 #(
    parameter int DATA_WIDTH                = 32,
    parameter int INSTR_WIDTH               = 32,
    parameter int ADDRESS_WIDTH             = 32,
    parameter int unsigned RESET_PC_ADDRESS = 0,
    parameter int IM_CAPACITY               = 32,
    parameter int DM_CAPACITY               = 32,
    parameter int MR_CAPACITY               = 32
) (
    input  logic                     CLK,
    input  logic                     HW_RSTn,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [1:0]               debug_func,
    input  logic                     debug_we,
    input  logic                     debug_re,
    input  logic                     mem_debug
);

    localparam int IM_AW = (IM_CAPACITY > 1) ? $clog2(IM_CAPACITY) : 1;
    localparam int DM_AW = (DM_CAPACITY > 1) ? $clog2(DM_CAPACITY) : 1;
    localparam int MR_AW = (MR_CAPACITY > 1) ? $clog2(MR_CAPACITY) : 1;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Byte addresses drop the low two bits; everything wraps modulo capacity.
    function automatic logic [IM_AW-1:0] im_idx(input logic [ADDRESS_WIDTH-1:0] a);
        return IM_AW'((a >> 2) % ADDRESS_WIDTH'(IM_CAPACITY));
    endfunction

    function automatic logic [DM_AW-1:0] dm_idx(input logic [ADDRESS_WIDTH-1:0] a);
        return DM_AW'((a >> 2) % ADDRESS_WIDTH'(DM_CAPACITY));
    endfunction

    function automatic logic [MR_AW-1:0] mr_idx(input logic [ADDRESS_WIDTH-1:0] a);
        return MR_AW'(a % ADDRESS_WIDTH'(MR_CAPACITY));
    endfunction

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   im_q [IM_CAPACITY];
    logic [INSTR_WIDTH-1:0]   im_d [IM_CAPACITY];
    logic [DATA_WIDTH-1:0]    dm_q [DM_CAPACITY];
    logic [DATA_WIDTH-1:0]    dm_d [DM_CAPACITY];
    logic [DATA_WIDTH-1:0]    mr_q [MR_CAPACITY];
    logic [DATA_WIDTH-1:0]    mr_d [MR_CAPACITY];

    logic [INSTR_WIDTH-1:0]   instr;
    logic [5:0]               opcode, funct;
    logic [4:0]               rs, rt, rd;
    logic [25:0]              target;
    logic [DATA_WIDTH-1:0]    sext_imm, rs_val, rt_val, ea;
    logic [ADDRESS_WIDTH-1:0] pc_plus4, next_pc;
    logic                     rf_we, dm_we;
    logic [4:0]               wr_reg;
    logic [MR_AW-1:0]         wr_idx;
    logic [DATA_WIDTH-1:0]    wr_val;
    logic                     unused_shamt;

    assign instr    = im_q[im_idx(pc_q)];
    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign target   = instr[25:0];
    assign sext_imm = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
    assign unused_shamt = ^instr[10:6];

    // Register 0 is never written, so reading it through the array yields 0.
    assign rs_val   = mr_q[mr_idx(ADDRESS_WIDTH'(rs))];
    assign rt_val   = mr_q[mr_idx(ADDRESS_WIDTH'(rt))];
    assign ea       = rs_val + sext_imm;
    assign pc_plus4 = pc_q + ADDRESS_WIDTH'(4);
    assign wr_idx   = mr_idx(ADDRESS_WIDTH'(wr_reg));

    // Decode and execute the current instruction: ALU result, writeback target, next PC.
    always_comb begin
        rf_we   = 1'b0;
        dm_we   = 1'b0;
        wr_reg  = rd;
        wr_val  = '0;
        next_pc = pc_plus4;
        case (opcode)
            OP_R: begin
                rf_we = 1'b1;
                case (funct)
                    FN_ADD:  wr_val = rs_val + rt_val;
                    FN_SUB:  wr_val = rs_val - rt_val;
                    FN_AND:  wr_val = rs_val & rt_val;
                    FN_OR:   wr_val = rs_val | rt_val;
                    FN_NOR:  wr_val = ~(rs_val | rt_val);
                    FN_SLT:  wr_val = DATA_WIDTH'($signed(rs_val) < $signed(rt_val));
                    default: rf_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                rf_we  = 1'b1;
                wr_reg = rt;
                wr_val = rs_val + sext_imm;
            end
            OP_LW: begin
                rf_we  = 1'b1;
                wr_reg = rt;
                wr_val = dm_q[dm_idx(ea)];
            end
            OP_SW:   dm_we = 1'b1;
            OP_BEQ:  if (rs_val == rt_val) next_pc = pc_plus4 + (sext_imm << 2);
            OP_J:    next_pc = {pc_plus4[31:28], target, 2'b00};
            default: ;
        endcase
    end

    // Next-state for PC and arrays: debug writes while halted, instruction commit while running.
    always_comb begin
        pc_d = pc_q;
        im_d = im_q;
        dm_d = dm_q;
        mr_d = mr_q;
        if (mem_debug) begin
            if (debug_we) begin
                case (debug_func)
                    2'd1: im_d[im_idx(addr)] = din;
                    2'd2: dm_d[dm_idx(addr)] = din;
                    2'd3: if (mr_idx(addr) != '0) mr_d[mr_idx(addr)] = din;
                    default: ;
                endcase
            end
        end else begin
            pc_d = next_pc;
            if (rf_we && wr_idx != '0) mr_d[wr_idx] = wr_val;
            if (dm_we) dm_d[dm_idx(ea)] = rt_val;
        end
    end

    // Combinational debug read; shows the pre-write value until the write edge.
    always_comb begin
        dout = '0;
        if (mem_debug && debug_re) begin
            case (debug_func)
                2'd1:    dout = im_q[im_idx(addr)];
                2'd2:    dout = dm_q[dm_idx(addr)];
                2'd3:    dout = mr_q[mr_idx(addr)];
                default: dout = '0;
            endcase
        end
    end

    // State registers; reset clears PC and every array entry immediately.
    always_ff @(posedge CLK or posedge HW_RSTn) begin
        if (HW_RSTn) begin
            pc_q <= ADDRESS_WIDTH'(RESET_PC_ADDRESS);
            for (int i = 0; i < IM_CAPACITY; i++) im_q[i] <= '0;
            for (int i = 0; i < DM_CAPACITY; i++) dm_q[i] <= '0;
            for (int i = 0; i < MR_CAPACITY; i++) mr_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            im_q <= im_d;
            dm_q <= dm_d;
            mr_q <= mr_d;
        end
    end

endmodule

// File: tb/tb_mpa_mips_32.sv
// tb_mpa_mips_32: directed and randomized program checks against an ISA-level model.
module tb_mpa_mips_32;

    logic        CLK = 1'b0;
    logic        HW_RSTn;
    logic [31:0] din, dout, addr;
    logic [1:0]  debug_func;
    logic        debug_we, debug_re, mem_debug;

    int n_tests = 0;
    int n_fail  = 0;

    // ISA-level model state
    logic [31:0] im_m [32];
    logic [31:0] dm_m [32];
    logic [31:0] mr_m [32];
    logic [31:0] pc_m;

    mpa_mips_32 dut (
        .CLK(CLK), .HW_RSTn(HW_RSTn), .din(din), .dout(dout), .addr(addr),
        .debug_func(debug_func), .debug_we(debug_we), .debug_re(debug_re),
        .mem_debug(mem_debug)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int w_ix(input logic [31:0] a);
        return int'((a >> 2) % 32);
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int f);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(f)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int t);
        return {6'h02, 26'(t)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            im_m[i] = '0; dm_m[i] = '0; mr_m[i] = '0;
        end
        pc_m = '0;
    endfunction

    // One instruction of the architectural model.
    function automatic void model_step();
        logic [31:0] ins, a, b, sx, pc4, npc, res;
        int dst;
        bit wr;
        ins = im_m[w_ix(pc_m)];
        a   = mr_m[ins[25:21]];
        b   = mr_m[ins[20:16]];
        sx  = {{16{ins[15]}}, ins[15:0]};
        pc4 = pc_m + 4;
        npc = pc4;
        wr  = 0; dst = 0; res = 0;
        case (ins[31:26])
            6'h00: begin
                dst = ins[15:11]; wr = 1;
                case (ins[5:0])
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 0;
                endcase
            end
            6'h08: begin dst = ins[20:16]; wr = 1; res = a + sx; end
            6'h23: begin dst = ins[20:16]; wr = 1; res = dm_m[w_ix(a + sx)]; end
            6'h2B: dm_m[w_ix(a + sx)] = b;
            6'h04: if (a == b) npc = pc4 + (sx << 2);
            6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        if (wr && dst != 0) mr_m[dst] = res;
        pc_m = npc;
    endfunction

    task automatic dbg_wr(input int func, input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        mem_debug = 1; debug_we = 1; debug_func = 2'(func); addr = a; din = d;
        @(posedge CLK);
        #1 debug_we = 0;
        case (func)
            1: im_m[w_ix(a)] = d;
            2: dm_m[w_ix(a)] = d;
            3: if (a % 32 != 0) mr_m[a % 32] = d;
            default: ;
        endcase
    endtask

    task automatic dbg_rd(input int func, input logic [31:0] a, output logic [31:0] d);
        debug_func = 2'(func); addr = a; debug_re = 1;
        #1 d = dout;
        debug_re = 0;
    endtask

    // Run n instructions while toggling the (ignored) debug controls.
    task automatic run(input int n);
        @(negedge CLK);
        mem_debug = 0; debug_we = 1; debug_re = 1; debug_func = 2'd2;
        addr = $urandom; din = $urandom;
        #1 chk("run_dout_zero", dout, 32'h0);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            model_step();
        end
        @(negedge CLK);
        mem_debug = 1; debug_we = 0; debug_re = 0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] v;
        for (int i = 0; i < 32; i++) begin
            dbg_rd(3, i, v);     chk({tag, "_mr"}, v, mr_m[i]);
            dbg_rd(2, i * 4, v); chk({tag, "_dm"}, v, dm_m[i]);
            dbg_rd(1, i * 4, v); chk({tag, "_im"}, v, im_m[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        HW_RSTn = 1;
        #3 HW_RSTn = 0;
        model_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        int k, rs, rt, rd;
        int fn [6] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h27, 32'h2A};
        k  = int'($urandom_range(0, 11));
        rs = int'($urandom_range(0, 7));
        rt = int'($urandom_range(0, 7));
        rd = int'($urandom_range(0, 7));
        case (k)
            0, 1, 2, 3, 4, 5: return enc_r(rs, rt, rd, fn[k]);
            6:  return enc_i(8'h08, rs, rt, int'($urandom_range(0, 65535)));
            7:  return enc_i(8'h23, rs, rt, int'($urandom_range(0, 255)) - 128);
            8:  return enc_i(8'h2B, rs, rt, int'($urandom_range(0, 255)) - 128);
            9:  return enc_i(8'h04, rs, rt, int'($urandom_range(0, 6)) - 3);
            10: return enc_j(int'($urandom_range(0, 40)));
            default: return $urandom_range(0, 1) ? enc_r(rs, rt, rd, 6'h00)
                                                 : enc_i(8'h3F, rs, rt, int'($urandom_range(0, 65535)));
        endcase
    endfunction

    initial begin
        logic [31:0] v;
        HW_RSTn = 1; din = 0; addr = 0; debug_func = 0;
        debug_we = 0; debug_re = 0; mem_debug = 1;
        model_reset();
        #12 HW_RSTn = 0;
        check_all("reset");

        // debug round trip and wrap
        dbg_wr(2, 8, 32'hDEADBEEF);
        dbg_rd(2, 8, v);   chk("dm8_rd", v, 32'hDEADBEEF);
        dbg_rd(2, 136, v); chk("dm136_wrap", v, 32'hDEADBEEF);

        // register 0 protection and MR wrap
        dbg_wr(3, 0, 32'h1234);
        dbg_rd(3, 0, v);  chk("mr0_prot", v, 32'h0);
        dbg_wr(3, 5, 32'h1234);
        dbg_rd(3, 5, v);  chk("mr5_rd", v, 32'h1234);
        dbg_rd(3, 37, v); chk("mr37_wrap", v, 32'h1234);

        // simultaneous write and read: old value before edge, new after
        @(negedge CLK);
        debug_func = 2'd2; addr = 8; din = 32'hCAFEF00D; debug_we = 1; debug_re = 1;
        #1 chk("rw_pre", dout, 32'hDEADBEEF);
        @(posedge CLK);
        #1 chk("rw_post", dout, 32'hCAFEF00D);
        debug_we = 0; debug_re = 0;
        dm_m[2] = 32'hCAFEF00D;

        // reset mid-operation clears immediately
        dbg_wr(1, 0, 32'h20010005);
        @(negedge CLK);
        #2 HW_RSTn = 1;
        #1 dbg_rd(2, 8, v); chk("rst_async_dm", v, 32'h0);
        HW_RSTn = 0;
        model_reset();
        check_all("reset2");

        // straight-line program
        dbg_wr(1, 0,  enc_i(8'h08, 0, 1, 5));
        dbg_wr(1, 4,  enc_i(8'h08, 0, 2, -3));
        dbg_wr(1, 8,  enc_r(1, 2, 3, 6'h20));
        dbg_wr(1, 12, enc_r(2, 1, 4, 6'h2A));
        dbg_wr(1, 16, enc_i(8'h2B, 0, 3, 4));
        dbg_wr(1, 20, enc_i(8'h23, 0, 5, 4));
        run(6);
        dbg_rd(3, 1, v); chk("prog_mr1", v, 32'd5);
        dbg_rd(3, 2, v); chk("prog_mr2", v, 32'hFFFFFFFD);
        dbg_rd(3, 3, v); chk("prog_mr3", v, 32'd2);
        dbg_rd(3, 4, v); chk("prog_mr4", v, 32'd1);
        dbg_rd(2, 4, v); chk("prog_dm1", v, 32'd2);
        dbg_rd(3, 5, v); chk("prog_mr5", v, 32'd2);
        check_all("prog");

        // control flow: counting loop with a skipped instruction
        do_reset();
        dbg_wr(1, 0,  enc_i(8'h08, 1, 1, 1));
        dbg_wr(1, 4,  enc_i(8'h04, 0, 0, 1));
        dbg_wr(1, 8,  enc_i(8'h08, 2, 2, 1));
        dbg_wr(1, 12, enc_j(0));
        run(12);
        dbg_rd(3, 1, v); chk("loop_mr1", v, 32'd4);
        dbg_rd(3, 2, v); chk("loop_skip_mr2", v, 32'd0);

        // halt: ten debug cycles with a write to no target
        @(negedge CLK);
        mem_debug = 1; debug_we = 1; debug_func = 2'd0; addr = 32'd4; din = $urandom;
        repeat (10) @(posedge CLK);
        #1 debug_we = 0;
        dbg_rd(3, 1, v); chk("halt_mr1", v, 32'd4);
        check_all("halt");
        run(3);
        dbg_rd(3, 1, v); chk("resume_mr1", v, 32'd5);
        dbg_rd(3, 2, v); chk("resume_mr2", v, 32'd0);

        // randomized programs against the model
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 1; i < 8; i++) dbg_wr(3, i, $urandom);
            for (int i = 0; i < 8; i++) dbg_wr(2, i * 4, $urandom);
            for (int i = 0; i < 32; i++) dbg_wr(1, i * 4, rand_instr());
            run(40);
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mpa_mips_32.md
# mpa_mips_32

Single-cycle 32-bit MIPS core with internal instruction memory (IM), data memory (DM) and register file (MR), plus a debug port for loading and inspecting all three. It is the top-level CPU of the MPA design. The core executes one instruction per clock while debug mode is off. While debug mode is on, the core halts and the memories are accessed through din/dout/addr.

## Interface
- DATA_WIDTH, 32: datapath and memory word width.
- INSTR_WIDTH, 32: instruction width.
- ADDRESS_WIDTH, 32: width of addr and PC.
- RESET_PC_ADDRESS, 0: PC value after reset.
- IM_CAPACITY, 32: IM depth in words; byte-addressed.
- DM_CAPACITY, 32: DM depth in words; byte-addressed.
- MR_CAPACITY, 32: register count; word-indexed.

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- HW_RSTn  in  1  reset, asynchronous, active-high.
- din  in  DATA_WIDTH  debug write data.
- dout  out  DATA_WIDTH  debug read data.
- addr  in  ADDRESS_WIDTH  debug address.
- debug_func  in  2  target select: 0 none, 1 IM, 2 DM, 3 MR.
- debug_we  in  1  debug write enable.
- debug_re  in  1  debug read enable.
- mem_debug  in  1  1 = debug mode (core halted), 0 = run.

## Operation
- **Reset** (HW_RSTn=1): PC=RESET_PC_ADDRESS, and all IM, DM and MR entries are cleared to 0.
- **Index mapping:**
  - IM/DM index = addr[..:2] modulo capacity; the low 2 bits are ignored.
  - MR index = addr modulo MR_CAPACITY.
  - Out-of-range addresses wrap.
- **Debug mode** (mem_debug=1):
  - PC frozen; core makes no register or memory writes.
  - debug_we=1 with debug_func≠0: at posedge, the selected memory[index] ← din.
  - Writes to MR[0] are ignored.
  - dout is combinational: equals selected memory[index] when debug_re=1 and debug_func≠0; otherwise 0.
  - debug_we and debug_re both high: the write occurs at the edge, and dout shows the pre-write value until the edge.
- **Run mode** (mem_debug=0):
  - debug_we, debug_re and debug_func are ignored; dout=0.
  - Each posedge executes IM[PC index].
- **Supported instructions:**
  - R-type, opcode 0, by funct: add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- **Unsupported opcode/funct:** treated as NOP; PC+4.
- **Arithmetic:**
  - Two's-complement, 32-bit wraparound, no overflow trap.
  - slt is a signed compare.
  - Immediates are sign-extended.
- **Memory addressing:** lw/sw effective address = rs + sext(imm), mapped to DM as above.
- **Next PC:**
  - Default PC+4.
  - beq taken: PC+4 + (sext(imm)<<2).
  - j: {PC+4[31:28], target, 2'b00}.
  - PC wraps through IM by the index mapping.
- **Register file:**
  - MR[0] always reads 0.
  - Writes to MR[0] are discarded.
  - rd is the destination for R-type; rt for addi/lw.

## Timing
- Single cycle per instruction:
  - Register read, ALU and DM read are combinational.
  - Register writeback, DM store and PC update occur on the same posedge.
- Debug write latency: 1 edge. Debug read latency: combinational from addr/debug_re/debug_func.
- mem_debug going 1→0: execution starts at the current PC on the next posedge.
- mem_debug going 0→1: no instruction commits at that edge.
- Reset asserted mid-operation: immediately clears PC and all memories, regardless of mem_debug. The first instruction executes at the first posedge after deassertion with mem_debug=0.

## Test plan
- **Reset:** assert HW_RSTn; debug-read IM/DM/MR over all addresses → all 0, PC=0.
- **Debug round-trip:**
  - Write DM addr 8 with 0xDEADBEEF, read it back → 0xDEADBEEF.
  - Read DM addr 136 → same word (wrap to index 2).
- **MR[0] protection:** debug write MR addr 0 with 0x1234 → read returns 0. MR addr 5 write/read → 0x1234.
- **Program run:**
  - Program in IM: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sw $3,4($0); lw $5,4($0).
  - Run 6 cycles → MR1=5, MR2=0xFFFFFFFD, MR3=2, MR4=1, DM word1=2, MR5=2.
- **Control flow:**
  - beq $0,$0,+1 skips the next instruction.
  - j 0 loops back to PC 0; verified with addi $1,$1,1 counting loop iterations.
- **Halt:** with mem_debug=1 for 10 cycles, PC and MR values are unchanged; debug_we with debug_func=0 changes nothing.
